boardman_v2_host: RTL and testbench
===================================

// Module: boardman_v2_host
// PURPOSE
// Host-side initiator for the board-manager serial protocol. Turns single-word
// read/write requests into COBS-framed packets on a byte stream toward the
// UART TX. It then decodes the COBS-framed reply arriving from the UART RX and
// returns the read data, or an error, to the requester. It is the counterpart
// of the board-side boardman responder and is used on the TURF/host FPGA.
// PARAMETERS
// TIMEOUT_CYCLES  100000  clocks to wait for a reply end-of-frame; used only with BOARDMAN_HOST_TIMEOUT_EN
// PORTS
// clk           in   1   system clock
// rst           in   1   asynchronous reset, active-high
// req_adr_i     in   20  word address (byte address = {adr,2'b00})
// req_dat_i     in   32  write data
// req_wr_i      in   1   1=write, 0=read
// req_valid_i   in   1   request valid
// req_ready_o   out  1   request accepted when valid&ready
// rsp_dat_o     out  32  read data; 0 for writes and errors
// rsp_err_o     out  1   reply malformed, address mismatch, or timeout
// rsp_valid_o   out  1   one-cycle strobe; rsp_dat_o/rsp_err_o valid
// m_axis_tdata  out  8   encoded bytes to UART TX, including 0x00 delimiter
// m_axis_tvalid out  1
// m_axis_tready in   1
// s_axis_tdata  in   8   encoded bytes from UART RX
// s_axis_tvalid in   1
// s_axis_tready out  1
// BEHAVIOUR
// - Reset: req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, m_axis_tvalid=0,
//   s_axis_tready=0, state=IDLE. The first cycle after reset release drives req_ready_o=1.
// - Payload fields (raw, MSB first):
//   A2={wr,1'b0,adr[19:14]}, A1=adr[13:6], A0={adr[5:0],2'b00}.
//   A write sends A2 A1 A0 D3 D2 D1 D0 (D3=dat[31:24]). A read sends A2 A1 A0.
// - The reply payload echoes A2 A1 A0. A read reply adds D3..D0, 7 bytes. A write reply is 3 bytes.
// - States: IDLE -> ENC -> TX -> RX -> RSP -> IDLE.
//   IDLE: req_ready_o=1. On accept, latch the payload into a 7-byte buffer. req_ready_o=0 until RSP.
//   ENC: one cycle per payload byte. Compute the COBS code for each group
//   (distance to the next zero byte or end, +1). Maximum payload is 7, so the code is always <=8.
//   TX: emit code/data bytes with AXI4-S handshake (tdata stable while tvalid&!tready). Data bytes
//   equal to 0x00 are not sent; they are replaced by the next code. After the final group, emit 0x00,
//   then go to RX.
//   RX: s_axis_tready=1. COBS-decode on the fly: a code byte c is followed by c-1 literal bytes, then an
//   implied 0x00 unless c==0xFF or the next byte is the delimiter. Store up to 7 decoded bytes.
//   An 8th byte sets an overflow flag. Input 0x00 ends the frame and moves to RSP.
//   RSP: one cycle. rsp_valid_o=1. rsp_err_o=1 if any of these holds:
//     * overflow;
//     * decoded length !=7 (read) or !=3 (write);
//     * echo != A2 A1 A0;
//     * a code byte ran past the delimiter.
//   rsp_dat_o={D3,D2,D1,D0} for a good read, else 0.
// - Bytes arriving on s_axis outside RX are accepted (tready=1) and dropped, so stale/unsolicited
//   frames never block the UART. A zero-length frame (leading 0x00) in RX is ignored. RX stays active.
// - A new request is accepted in the cycle after RSP, never in the same cycle.
// - Latency: request to first m_axis byte = 1 + payload length cycles.
// - An async reset in any state aborts the transaction. No rsp_valid_o is produced. A partial TX frame
//   is simply cut off; the far end resyncs on the next 0x00.
// CONFIGURATION
// - BOARDMAN_HOST_TIMEOUT_EN defined:
//   * A counter is cleared on RX entry and on every accepted s_axis byte.
//   * When it reaches TIMEOUT_CYCLES-1, go to RSP with rsp_err_o=1, rsp_dat_o=0.
//   * A late reply is then dropped by the IDLE discard rule.
// - BOARDMAN_HOST_TIMEOUT_EN undefined: no counter is built; RX waits indefinitely for a 0x00.
// TESTING
// - Write adr=0x00010, dat=0x00AB0000, tready=1 -> m_axis emits 02 80 02 40 02 AB 01 01 00.
// - Read adr=0x00001 -> TX 01 01 02 04 00. Inject reply 01 01 06 04 12 34 56 78 00
//   -> rsp_valid_o 1 cycle, rsp_dat_o=0x12345678, rsp_err_o=0.
// - Read adr=0x00001, reply 01 01 02 08 00 (echo mismatch) -> rsp_err_o=1, rsp_dat_o=0.
// - Write, reply 01 01 06 04 12 34 56 78 9A 00 (length wrong, then overflow) -> rsp_err_o=1.
// - m_axis_tready toggled 1/0 every cycle during a write -> byte sequence unchanged, tdata held while stalled.
// - With BOARDMAN_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=50, no reply -> rsp_err_o=1 exactly 50 clocks after the
//   delimiter is accepted. Assert rst mid-TX -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/boardman_v2_host.sv
// boardman_v2_host: host-side initiator for the board-manager serial protocol.
// Packs a single-word read/write request into a COBS frame toward UART TX and
// decodes the COBS reply from UART RX into read data or an error strobe.
// Optional reply timeout is built only when BOARDMAN_HOST_TIMEOUT_EN is defined.
module boardman_v2_host #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] req_adr_i,
   input  logic [31:0] req_dat_i,
   input  logic        req_wr_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        rsp_valid_o,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready
);

   typedef enum logic [2:0] {IDLE, ENC, TX, RX, RSP} state_t;

   state_t      state;

   // raw payload (entry 7 is never part of a frame, kept so 3-bit indices stay in range)
   logic [7:0]  pbuf [0:7];
   logic [2:0]  plen;
   // encoder: backward scan, run = non-zero bytes seen since the next zero/end
   logic [2:0]  enc_idx;
   logic [2:0]  run;
   // encoded frame body: txb[0] is the leading code, txb[i+1] replaces pbuf[i]
   logic [7:0]  txb [0:7];
   logic [3:0]  tx_idx;
   // decoder state
   logic [7:0]  rxb [0:7];
   logic [2:0]  rx_len;
   logic        rx_ovf;
   logic        rx_started;
   logic        rx_pend;
   logic [7:0]  rx_cnt;

`ifdef BOARDMAN_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
`endif

   logic        enc_zero;
   logic [2:0]  enc_run;
   logic [7:0]  enc_code;
   logic [7:0]  enc_first;
   logic        is_wr;
   logic [2:0]  exp_len;
   logic        echo_ok;
   logic        rsp_bad;
   logic        s_hs;
   logic        app_en;
   logic [7:0]  app_dat;

   // encoder step for the current byte and reply checks for the finished frame
   always_comb begin
      enc_zero  = (pbuf[enc_idx] == 8'h00);
      enc_run   = enc_zero ? 3'd0 : run + 3'd1;
      enc_code  = {5'd0, run} + 8'd1;
      enc_first = {5'd0, enc_run} + 8'd1;
      is_wr     = pbuf[0][7];
      exp_len   = is_wr ? 3'd3 : 3'd7;
      echo_ok   = (rxb[0] == pbuf[0]) && (rxb[1] == pbuf[1]) && (rxb[2] == pbuf[2]);
      // rx_cnt != 0 at the delimiter means a code byte promised more literals
      rsp_bad   = rx_ovf || (rx_len != exp_len) || !echo_ok || (rx_cnt != 8'd0);
      s_hs      = s_axis_tvalid && s_axis_tready;
      // code byte: emit the zero implied by the previous group; literal: store it
      app_en    = (rx_cnt == 8'd0) ? rx_pend : 1'b1;
      app_dat   = (rx_cnt == 8'd0) ? 8'h00 : s_axis_tdata;
   end

   // main protocol FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         req_ready_o   <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_err_o     <= 1'b0;
         rsp_dat_o     <= 32'd0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= 8'd0;
         s_axis_tready <= 1'b0;
         plen          <= 3'd0;
         enc_idx       <= 3'd0;
         run           <= 3'd0;
         tx_idx        <= 4'd0;
         rx_len        <= 3'd0;
         rx_ovf        <= 1'b0;
         rx_started    <= 1'b0;
         rx_pend       <= 1'b0;
         rx_cnt        <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            pbuf[i] <= 8'd0;
            txb[i]  <= 8'd0;
            rxb[i]  <= 8'd0;
         end
`ifdef BOARDMAN_HOST_TIMEOUT_EN
         tcnt          <= '0;
`endif
      end else begin
         // RX side never blocks; bytes outside RX are simply dropped
         s_axis_tready <= 1'b1;
         case (state)
            IDLE: begin
               req_ready_o <= 1'b1;
               if (req_valid_i && req_ready_o) begin
                  req_ready_o <= 1'b0;
                  pbuf[0]     <= {req_wr_i, 1'b0, req_adr_i[19:14]};
                  pbuf[1]     <= req_adr_i[13:6];
                  pbuf[2]     <= {req_adr_i[5:0], 2'b00};
                  pbuf[3]     <= req_dat_i[31:24];
                  pbuf[4]     <= req_dat_i[23:16];
                  pbuf[5]     <= req_dat_i[15:8];
                  pbuf[6]     <= req_dat_i[7:0];
                  pbuf[7]     <= 8'd0;
                  plen        <= req_wr_i ? 3'd7 : 3'd3;
                  enc_idx     <= req_wr_i ? 3'd6 : 3'd2;
                  run         <= 3'd0;
                  state       <= ENC;
               end
            end
            ENC: begin
               txb[enc_idx + 3'd1] <= enc_zero ? enc_code : pbuf[enc_idx];
               run <= enc_run;
               if (enc_idx == 3'd0) begin
                  txb[0]        <= enc_first;
                  m_axis_tdata  <= enc_first;
                  m_axis_tvalid <= 1'b1;
                  tx_idx        <= 4'd0;
                  state         <= TX;
               end else begin
                  enc_idx <= enc_idx - 3'd1;
               end
            end
            TX: begin
               if (m_axis_tvalid && m_axis_tready) begin
                  if (tx_idx == {1'b0, plen} + 4'd1) begin
                     // delimiter just went out
                     m_axis_tvalid <= 1'b0;
                     m_axis_tdata  <= 8'd0;
                     rx_len        <= 3'd0;
                     rx_ovf        <= 1'b0;
                     rx_started    <= 1'b0;
                     rx_pend       <= 1'b0;
                     rx_cnt        <= 8'd0;
`ifdef BOARDMAN_HOST_TIMEOUT_EN
                     tcnt          <= '0;
`endif
                     state         <= RX;
                  end else begin
                     tx_idx       <= tx_idx + 4'd1;
                     m_axis_tdata <= (tx_idx == {1'b0, plen}) ? 8'h00 : txb[tx_idx[2:0] + 3'd1];
                  end
               end
            end
            RX: begin
               if (s_hs) begin
`ifdef BOARDMAN_HOST_TIMEOUT_EN
                  tcnt <= '0;
`endif
                  if (s_axis_tdata == 8'h00) begin
                     // a leading delimiter is an empty frame and is ignored
                     if (rx_started) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= rsp_bad;
                        rsp_dat_o   <= (!rsp_bad && !is_wr) ? {rxb[3], rxb[4], rxb[5], rxb[6]} : 32'd0;
                        state       <= RSP;
                     end
                  end else begin
                     rx_started <= 1'b1;
                     if (app_en) begin
                        if (rx_len == 3'd7) begin
                           rx_ovf <= 1'b1;
                        end else begin
                           rxb[rx_len] <= app_dat;
                           rx_len      <= rx_len + 3'd1;
                        end
                     end
                     if (rx_cnt == 8'd0) begin
                        rx_cnt  <= s_axis_tdata - 8'd1;
                        rx_pend <= (s_axis_tdata != 8'hFF);
                     end else begin
                        rx_cnt <= rx_cnt - 8'd1;
                     end
                  end
               end
`ifdef BOARDMAN_HOST_TIMEOUT_EN
               else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
                  rsp_dat_o   <= 32'd0;
                  state       <= RSP;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
`endif
            end
            RSP: begin
               rsp_valid_o <= 1'b0;
               rsp_err_o   <= 1'b0;
               rsp_dat_o   <= 32'd0;
               req_ready_o <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boardman_v2_host.sv
// Directed bench for boardman_v2_host: frame encoding, reply decoding,
// error cases, TX backpressure, async reset abort and optional timeout.
module tb_boardman_v2_host;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] req_adr_i = '0;
   logic [31:0] req_dat_i = '0;
   logic        req_wr_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        rsp_valid_o;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;

   int tests = 0;
   int fails = 0;
   int rsp_cnt = 0;
   logic [31:0] rsp_dat_cap;
   logic        rsp_err_cap;
   logic [7:0]  tx_q  [0:15];
   int          tx_n;
   logic [7:0]  exp_b [0:15];
   logic [7:0]  rep   [0:15];

   boardman_v2_host #(.TIMEOUT_CYCLES(50)) dut (
      .clk(clk), .rst(rst),
      .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_wr_i(req_wr_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o), .rsp_valid_o(rsp_valid_o),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready)
   );

   always #5 clk = ~clk;

   // response strobe monitor
   always @(negedge clk) begin
      if (rsp_valid_o) begin
         rsp_cnt++;
         rsp_dat_cap = rsp_dat_o;
         rsp_err_cap = rsp_err_o;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // issue one request and capture the TX frame up to and including the delimiter
   task automatic do_req(input string tag, input logic [19:0] adr, input logic [31:0] dat,
                         input logic wr, input bit toggle, input int exp_lat);
      int cyc;
      bit done, seen, prev_stall, tr;
      logic [7:0] prev_dat;
      tx_n = 0;
      cyc = 0;
      while (!req_ready_o && cyc < 100) begin @(negedge clk); cyc++; end
      check({tag, "_req_ready"}, req_ready_o, 1);
      req_adr_i = adr; req_dat_i = dat; req_wr_i = wr; req_valid_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
      cyc = 1; seen = 0; done = 0; prev_stall = 0; tr = 1; prev_dat = 8'h00;
      while (!done && cyc < 200) begin
         m_axis_tready = toggle ? tr : 1'b1;
         tr = ~tr;
         if (m_axis_tvalid && !seen) begin
            seen = 1;
            check({tag, "_latency"}, cyc, exp_lat);
         end
         if (prev_stall) check({tag, "_hold"}, {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd1, prev_dat});
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_dat = m_axis_tdata;
         if (m_axis_tvalid && m_axis_tready && tx_n < 16) begin
            tx_q[tx_n] = m_axis_tdata;
            tx_n++;
            if (m_axis_tdata == 8'h00) done = 1;
         end
         @(negedge clk);
         cyc++;
      end
      m_axis_tready = 1'b1;
      check({tag, "_tx_done"}, done, 1);
   endtask

   task automatic check_tx(input string tag, input int n);
      check({tag, "_tx_len"}, tx_n, n);
      for (int i = 0; i < n; i++) check($sformatf("%s_tx_b%0d", tag, i), tx_q[i], exp_b[i]);
   endtask

   task automatic send_bytes(input int n);
      for (int i = 0; i < n; i++) begin
         s_axis_tdata = rep[i]; s_axis_tvalid = 1'b1;
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00;
   endtask

   task automatic reply_check(input string tag, input int n, input logic [31:0] edat, input logic eerr);
      int c0;
      c0 = rsp_cnt;
      check({tag, "_s_ready"}, s_axis_tready, 1);
      send_bytes(n);
      repeat (3) @(negedge clk);
      #1;
      check({tag, "_pulses"}, rsp_cnt - c0, 1);
      check({tag, "_dat"}, rsp_dat_cap, edat);
      check({tag, "_err"}, rsp_err_cap, eerr);
      check({tag, "_ready_back"}, req_ready_o, 1);
   endtask

   initial begin
      int c0, cyc;
      // reset values
      repeat (2) @(negedge clk);
      check("rst_req_ready", req_ready_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rsp_err", rsp_err_o, 0);
      check("rst_rsp_dat", rsp_dat_o, 0);
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_s_tready", s_axis_tready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rel_req_ready", req_ready_o, 1);

      // write with zeros in address and data
      do_req("wr1", 20'h00010, 32'h00AB0000, 1'b1, 1'b0, 8);
      exp_b = '{8'h02, 8'h80, 8'h02, 8'h40, 8'h02, 8'hAB, 8'h01, 8'h01, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_tx("wr1", 9);
      rep = '{8'h02, 8'h80, 8'h02, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      reply_check("wr1_rsp", 5, 32'd0, 1'b0);

      // good read
      do_req("rd1", 20'h00001, 32'h0, 1'b0, 1'b0, 4);
      exp_b = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_tx("rd1", 5);
      rep = '{8'h01, 8'h01, 8'h06, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      reply_check("rd1_rsp", 9, 32'h12345678, 1'b0);

      // echo mismatch
      do_req("rd2", 20'h00001, 32'h0, 1'b0, 1'b0, 4);
      rep = '{8'h01, 8'h01, 8'h02, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      reply_check("rd2_echo", 5, 32'd0, 1'b1);

      // write under toggling backpressure, then oversize reply
      do_req("wr2", 20'h00010, 32'h00AB0000, 1'b1, 1'b1, 8);
      exp_b = '{8'h02, 8'h80, 8'h02, 8'h40, 8'h02, 8'hAB, 8'h01, 8'h01, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_tx("wr2", 9);
      rep = '{8'h01, 8'h01, 8'h06, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h9A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      reply_check("wr2_ovf", 10, 32'd0, 1'b1);

      // unsolicited bytes in IDLE are dropped without a response
      c0 = rsp_cnt;
      rep = '{8'h05, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check("idle_s_ready", s_axis_tready, 1);
      send_bytes(4);
      repeat (2) @(negedge clk);
      #1;
      check("idle_drop_pulses", rsp_cnt - c0, 0);

      // max address, no zero bytes, leading empty frame, max code 8
      do_req("rd3", 20'hFFFFF, 32'h0, 1'b0, 1'b0, 4);
      exp_b = '{8'h04, 8'h3F, 8'hFF, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_tx("rd3", 5);
      rep = '{8'h00, 8'h08, 8'h3F, 8'hFF, 8'hFC, 8'hDE, 8'hAD, 8'hBE,
              8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      reply_check("rd3_rsp", 10, 32'hDEADBEEF, 1'b0);

      // correct length and echo, but code byte runs past the delimiter
      do_req("rd4", 20'hFFFFF, 32'h0, 1'b0, 1'b0, 4);
      rep = '{8'h09, 8'h3F, 8'hFF, 8'hFC, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      reply_check("rd4_runpast", 9, 32'd0, 1'b1);

      // async reset while TX is stalled
      c0 = rsp_cnt;
      m_axis_tready = 1'b0;
      req_adr_i = 20'h00010; req_dat_i = 32'h00AB0000; req_wr_i = 1'b1; req_valid_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
      cyc = 0;
      while (!m_axis_tvalid && cyc < 50) begin @(negedge clk); cyc++; end
      check("rst_mid_tvalid_pre", m_axis_tvalid, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_tvalid", m_axis_tvalid, 0);
      check("rst_mid_req_ready", req_ready_o, 0);
      check("rst_mid_s_ready", s_axis_tready, 0);
      check("rst_mid_rsp_valid", rsp_valid_o, 0);
      @(negedge clk);
      rst = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid_no_rsp", rsp_cnt - c0, 0);
      check("rst_mid_tvalid_after", m_axis_tvalid, 0);

      // recovery after reset
      do_req("rd5", 20'h00001, 32'h0, 1'b0, 1'b0, 4);
      exp_b = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_tx("rd5", 5);
      rep = '{8'h01, 8'h01, 8'h06, 8'h04, 8'hA5, 8'h5A, 8'h01, 8'hFE,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      reply_check("rd5_rsp", 9, 32'hA55A01FE, 1'b0);

`ifdef BOARDMAN_HOST_TIMEOUT_EN
      // no reply: error strobe exactly 50 clocks after the delimiter handshake
      do_req("to", 20'h00001, 32'h0, 1'b0, 1'b0, 4);
      cyc = 0;
      while (!rsp_valid_o && cyc < 200) begin @(negedge clk); cyc++; end
      check("to_cycles", cyc, 50);
      check("to_err", rsp_err_o, 1);
      check("to_dat", rsp_dat_o, 0);
      repeat (2) @(negedge clk);
      c0 = rsp_cnt;
      rep = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_bytes(5);
      repeat (2) @(negedge clk);
      #1;
      check("to_late_dropped", rsp_cnt - c0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
